// File: rtl/e_mdu.sv
// Execute-stage multiply/divide unit with HI/LO registers and a busy flag for hazard stalls.
// Optional MDU_FLUSH_EN adds a flush input that cancels an in-flight mult/div.
module e_mdu #(
    parameter int WIDTH       = 32,
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic             clk,
    input  logic             reset,
`ifdef MDU_FLUSH_EN
    input  logic             flush,
`endif
    input  logic             start,
    input  logic [2:0]       MDUop,
    input  logic [WIDTH-1:0] Op1,
    input  logic [WIDTH-1:0] Op2,
    output logic             busy,
    output logic             fsm_run,
    output logic [WIDTH-1:0] HI,
    output logic [WIDTH-1:0] LO
);
    // Handshake: a request is accepted when start=1 at a rising edge while idle;
    // busy is high from the accept edge until the edge that commits HI/LO.
    typedef enum logic {IDLE, RUN} state_t;

    localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW   = $clog2(MAXC + 1);
    localparam logic [CW-1:0] MULT_LOAD = CW'(MULT_CYCLES);
    localparam logic [CW-1:0] DIV_LOAD  = CW'(DIV_CYCLES);
    localparam logic [CW-1:0] CNT_ONE   = CW'(1);

    state_t              state;
    logic [CW-1:0]       cnt;
    logic [WIDTH-1:0]    sh_hi;
    logic [WIDTH-1:0]    sh_lo;
    logic                sh_wr;
    logic                do_flush;

`ifdef MDU_FLUSH_EN
    assign do_flush = flush;
`else
    assign do_flush = 1'b0;
`endif

    assign fsm_run = (state == RUN);

    logic [2*WIDTH-1:0]       prod_s;
    logic [2*WIDTH-1:0]       prod_u;
    logic                     div_zero;
    logic                     div_ovf;
    logic signed [WIDTH-1:0]  sdivisor;
    logic [WIDTH-1:0]         udivisor;
    logic signed [WIDTH-1:0]  q_s;
    logic signed [WIDTH-1:0]  r_s;
    logic [WIDTH-1:0]         q_u;
    logic [WIDTH-1:0]         r_u;

    // Sign-extended to full width, the low 2*WIDTH bits of an unsigned product are the signed product.
    assign prod_s = {{WIDTH{Op1[WIDTH-1]}}, Op1} * {{WIDTH{Op2[WIDTH-1]}}, Op2};
    assign prod_u = {{WIDTH{1'b0}}, Op1} * {{WIDTH{1'b0}}, Op2};

    // Dividing most-negative by -1 is replaced with a divide by 1, which yields the wrapped result.
    assign div_zero = (Op2 == '0);
    assign div_ovf  = (Op1 == {1'b1, {(WIDTH-1){1'b0}}}) && (Op2 == '1);
    assign sdivisor = (div_zero || div_ovf) ? WIDTH'(1) : $signed(Op2);
    assign udivisor = div_zero ? WIDTH'(1) : Op2;
    assign q_s = $signed(Op1) / sdivisor;
    assign r_s = $signed(Op1) % sdivisor;
    assign q_u = Op1 / udivisor;
    assign r_u = Op1 % udivisor;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            busy  <= 1'b0;
            cnt   <= '0;
            HI    <= '0;
            LO    <= '0;
            sh_hi <= '0;
            sh_lo <= '0;
            sh_wr <= 1'b0;
        end else if (do_flush) begin
            state <= IDLE;
            busy  <= 1'b0;
            cnt   <= '0;
            sh_wr <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        case (MDUop)
                            3'b000: begin
                                sh_hi <= prod_s[2*WIDTH-1:WIDTH];
                                sh_lo <= prod_s[WIDTH-1:0];
                                sh_wr <= 1'b1;
                                cnt   <= MULT_LOAD;
                                state <= RUN;
                                busy  <= 1'b1;
                            end
                            3'b001: begin
                                sh_hi <= prod_u[2*WIDTH-1:WIDTH];
                                sh_lo <= prod_u[WIDTH-1:0];
                                sh_wr <= 1'b1;
                                cnt   <= MULT_LOAD;
                                state <= RUN;
                                busy  <= 1'b1;
                            end
                            3'b010: begin
                                sh_hi <= r_s;
                                sh_lo <= q_s;
                                sh_wr <= !div_zero;
                                cnt   <= DIV_LOAD;
                                state <= RUN;
                                busy  <= 1'b1;
                            end
                            3'b011: begin
                                sh_hi <= r_u;
                                sh_lo <= q_u;
                                sh_wr <= !div_zero;
                                cnt   <= DIV_LOAD;
                                state <= RUN;
                                busy  <= 1'b1;
                            end
                            3'b100:  HI <= Op1;
                            3'b101:  LO <= Op1;
                            default: ;
                        endcase
                    end
                end
                RUN: begin
                    if (cnt <= CNT_ONE) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        cnt   <= '0;
                        if (sh_wr) begin
                            HI <= sh_hi;
                            LO <= sh_lo;
                        end
                    end else begin
                        cnt <= cnt - CNT_ONE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
